// File: rtl/irq_pkg.sv
// irq_pkg: state encoding, vector defaults and address helper
// shared by the interrupt controller and its sub-blocks.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_state_e;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam int          VEC_STRIDE_DEF = 4;

  // Wraps modulo 2^32 by construction.
  function automatic logic [31:0] vec_addr(
    input logic [31:0] base,
    input logic [31:0] stride,
    input logic [31:0] id
  );
    return base + id * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder
// with a valid flag.
module irq_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 5
) (
  input  logic [N-1:0]    i_req,
  output logic            o_valid,
  output logic [ID_W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = ID_W'(i);
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched pending bits, enable mask, req/grant/done
// arbiter. Define IRQ_SYNC_EN to add a 2-flop input synchronizer.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int          ID_W       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               enable_we_i,
  input  logic [NUM_IRQ-1:0] enable_wdata_i,
  input  logic               irq_grant_i,
  input  logic               irq_done_i,
  output logic               irq_req_o,
  output logic [31:0]        irq_addr_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic               irq_active_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [NUM_IRQ-1:0] overrun_o
);

  logic [NUM_IRQ-1:0] w_src;
  logic [NUM_IRQ-1:0] r_src_q;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_ovr;
  logic [NUM_IRQ-1:0] r_en;
  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_clr;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    w_sel;
  logic               w_valid;
  logic               w_take;
  irq_state_e         r_state;
  irq_state_e         w_next;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src_i;
`endif

  assign w_edge = w_src & ~r_src_q;
  assign w_cand = r_pend & r_en;
  assign w_take = (r_state == REQ) && irq_grant_i;
  assign w_clr  = w_take ? (NUM_IRQ'(1) << r_id) : '0;

  irq_prio_enc #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_enc (
    .i_req   (w_cand),
    .o_valid (w_valid),
    .o_idx   (w_sel)
  );

  // A new edge beats the grant clear on the same bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src_q <= '0;
      r_pend  <= '0;
      r_ovr   <= '0;
      r_en    <= '0;
      r_id    <= '0;
    end else begin
      r_src_q <= w_src;
      r_pend  <= (r_pend & ~w_clr) | w_edge;
      if (enable_we_i) begin
        r_en  <= enable_wdata_i;
        r_ovr <= (r_ovr | (w_edge & r_pend)) & enable_wdata_i;
      end else begin
        r_ovr <= r_ovr | (w_edge & r_pend);
      end
      if (r_state == IDLE && w_valid) r_id <= w_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_valid)     w_next = REQ;
      REQ:     if (irq_grant_i) w_next = ACTIVE;
      ACTIVE:  if (irq_done_i)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    irq_req_o    = (r_state == REQ);
    irq_active_o = (r_state == ACTIVE);
  end

  assign irq_id_o   = r_id;
  assign irq_addr_o = vec_addr(VEC_BASE, 32'(VEC_STRIDE), 32'(r_id));
  assign pending_o  = r_pend;
  assign overrun_o  = r_ovr;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus random traffic checked
// against a behavioural model every cycle.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  src;
  logic        we;
  logic [7:0]  wdata;
  logic        grant;
  logic        done;
  logic        req;
  logic [31:0] addr;
  logic [4:0]  id;
  logic        act;
  logic [7:0]  pend;
  logic [7:0]  ovr;

  int total = 0;
  int bad   = 0;

  irq_controller dut (
    .clk            (clk),
    .reset          (reset),
    .irq_src_i      (src),
    .enable_we_i    (we),
    .enable_wdata_i (wdata),
    .irq_grant_i    (grant),
    .irq_done_i     (done),
    .irq_req_o      (req),
    .irq_addr_o     (addr),
    .irq_id_o       (id),
    .irq_active_o   (act),
    .pending_o      (pend),
    .overrun_o      (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 requesting, 2 servicing.
  logic [7:0] m_pend, m_ovr, m_en, m_q, m_s1, m_s2;
  int m_ph;
  int m_id;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ovr = 0; m_en = 0; m_q = 0;
    m_s1 = 0; m_s2 = 0; m_ph = 0; m_id = 0;
  endtask

  task automatic model_step();
    logic [7:0] s, e, c, np, one;
`ifdef IRQ_SYNC_EN
    s = m_s2; m_s2 = m_s1; m_s1 = src;
`else
    s = src;
`endif
    e = s & ~m_q;
    m_q = s;
    c = m_pend & m_en;
    one = 8'(1 << m_id);
    np = m_pend | e;
    if (m_ph == 1 && grant) np = (m_pend & ~one) | e;
    m_ovr = m_ovr | (e & m_pend);
    if (we) begin
      m_ovr = m_ovr & wdata;
      m_en = wdata;
    end
    if (m_ph == 0 && c != 0) begin
      m_ph = 1;
      m_id = lowest(c);
    end else if (m_ph == 1 && grant) begin
      m_ph = 2;
    end else if (m_ph == 2 && done) begin
      m_ph = 0;
    end
    m_pend = np;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("m_req", 32'(req), 32'(m_ph == 1));
      chk("m_act", 32'(act), 32'(m_ph == 2));
      chk("m_pend", 32'(pend), 32'(m_pend));
      chk("m_ovr", 32'(ovr), 32'(m_ovr));
      if (m_ph == 1) begin
        chk("m_id", 32'(id), 32'(m_id));
        chk("m_addr", addr, 32'h100 + 32'(m_id) * 4);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (req !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("wait_req", 32'(req), 32'd1);
  endtask

  task automatic set_en(input logic [7:0] v);
    we = 1; wdata = v;
    tick();
    we = 0;
  endtask

  task automatic serve();
    grant = 1;
    tick();
    grant = 0;
    done = 1;
    tick();
    done = 0;
  endtask

  task automatic pulse(input logic [7:0] v);
    src = v;
    tick();
    src = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_act", 32'(act), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_addr", addr, 32'h100);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
  endtask

  initial begin
    reset = 0; src = 0; we = 0; wdata = 0; grant = 0; done = 0;
    repeat (3) tick();
    chk_reset_vals();
    reset = 1;
    tick();

    // Single source 3
    set_en(8'hFF);
    src = 8'h08;
    tick();
    src = 0;
    repeat (XL) tick();
    chk("s1_pend", 32'(pend), 32'h08);
    chk("s1_req0", 32'(req), 32'd0);
    tick();
    chk("s1_req", 32'(req), 32'd1);
    chk("s1_id", 32'(id), 32'd3);
    chk("s1_addr", addr, 32'h10C);
    grant = 1;
    tick();
    grant = 0;
    chk("s1_pclr", 32'(pend), 32'd0);
    chk("s1_act", 32'(act), 32'd1);
    done = 1;
    tick();
    done = 0;
    chk("s1_idle", 32'(act), 32'd0);

    // Two at once: lower index first
    pulse(8'h24);
    wait_req();
    chk("s2_id_a", 32'(id), 32'd2);
    chk("s2_addr_a", addr, 32'h108);
    serve();
    wait_req();
    chk("s2_id_b", 32'(id), 32'd5);
    chk("s2_addr_b", addr, 32'h114);
    serve();

    // Masked source, then enabled
    set_en(8'h00);
    pulse(8'h02);
    repeat (XL + 3) tick();
    chk("s3_pend", 32'(pend), 32'h02);
    chk("s3_noreq", 32'(req), 32'd0);
    we = 1; wdata = 8'h02;
    tick();
    we = 0;
    chk("s3_req0", 32'(req), 32'd0);
    tick();
    chk("s3_req", 32'(req), 32'd1);
    chk("s3_id", 32'(id), 32'd1);
    serve();

    // No re-arbitration once requesting
    set_en(8'hFF);
    pulse(8'h10);
    wait_req();
    pulse(8'h01);
    repeat (XL + 3) tick();
    chk("s4_id", 32'(id), 32'd4);
    chk("s4_addr", addr, 32'h110);
    serve();
    wait_req();
    chk("s4_id_next", 32'(id), 32'd0);
    serve();

    // Overrun and set-beats-clear
    set_en(8'h00);
    pulse(8'h40);
    tick();
    pulse(8'h40);
    repeat (XL + 1) tick();
    chk("s5_ovr", 32'(ovr), 32'h40);
    chk("s5_pend", 32'(pend), 32'h40);
    set_en(8'h40);
    wait_req();
    chk("s5_id", 32'(id), 32'd6);
    src = 8'h40;
    repeat (XL) tick();
    grant = 1;
    tick();
    grant = 0;
    src = 0;
    chk("s5_keep", 32'(pend), 32'h40);
    chk("s5_act", 32'(act), 32'd1);
    done = 1;
    tick();
    done = 0;
    wait_req();
    serve();

    // Async reset while servicing
    set_en(8'hFF);
    pulse(8'h04);
    wait_req();
    grant = 1;
    tick();
    grant = 0;
    chk("s6_act", 32'(act), 32'd1);
    #2 reset = 0;
    #1 chk_reset_vals();
    tick();
    reset = 1;
    tick();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      src = src ^ 8'($urandom & $urandom & $urandom);
      we = ($urandom_range(0, 15) == 0);
      wdata = 8'($urandom | $urandom);
      grant = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 3) == 0);
      tick();
    end
    src = 0; we = 0; grant = 0; done = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt source collector and arbiter upstream of core_controller_fsm.
- Latches rising edges on NUM_IRQ external lines into per-source pending bits, gated by a software-writable enable mask.
- Selects the highest-priority pending source (lowest index wins) and issues a request/grant/done handshake carrying the handler vector address.
- Drives the controller's irq_req_i/irq_addr_i and initiate signal; consumes its irq_grant_o and irq_service_done.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..32).
- VEC_BASE, 32'h0000_0100, handler address for source 0.
- VEC_STRIDE, 4, byte spacing between consecutive handler vectors.
- ID_W, 5, width of the source index output.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- irq_src_i  input  NUM_IRQ  raw interrupt lines, rising-edge sensitive.
- enable_we_i  input  1  write strobe for the enable mask.
- enable_wdata_i  input  NUM_IRQ  new enable mask value.
- irq_grant_i  input  1  core accepted the request (from irq_grant_o).
- irq_done_i  input  1  handler returned (from irq_service_done).
- irq_req_o  output  1  request to core; also feeds initate_irq.
- irq_addr_o  output  32  handler vector for the selected source.
- irq_id_o  output  ID_W  selected source index.
- irq_active_o  output  1  a granted interrupt is being serviced.
- pending_o  output  NUM_IRQ  current pending bits.
- overrun_o  output  NUM_IRQ  sticky flag: an edge arrived while that bit was already pending.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; pending, overrun and enable clear to 0; src_q clears to 0; irq_req_o=0, irq_active_o=0, irq_id_o=0, irq_addr_o=VEC_BASE.
- Edge detect:
  - src_q <= irq_src_i on every edge.
  - edge[i] = irq_src_i[i] & ~src_q[i].
  - pending[i] sets on the clock edge where edge[i]=1.
  - If edge[i]=1 while pending[i]=1, overrun[i] is set. overrun clears only when enable_we_i writes 0 to that bit's enable.
- Enable mask: enable <= enable_wdata_i when enable_we_i=1. Disabled sources still latch pending but are never selected.
- Selection: cand = pending & enable; sel = index of lowest set bit in cand.
- FSM states IDLE, REQ, ACTIVE:
  - IDLE: if cand!=0, latch id<=sel and go to REQ. Latency: edge seen at clock E0 gives pending at E0 and irq_req_o=1 after E1.
  - REQ: irq_req_o=1. irq_id_o and irq_addr_o = VEC_BASE + id*VEC_STRIDE (32-bit, wraps modulo 2^32) are stable and unchanged until grant. The controller is committed to the latched id: no re-arbitration, even if a higher-priority source arrives or enable[id] is cleared. On irq_grant_i: clear pending[id] and go to ACTIVE. irq_done_i is ignored in REQ.
  - ACTIVE: irq_active_o=1 and irq_req_o=0. On irq_done_i go to IDLE. irq_grant_i is ignored. No nesting.
- Simultaneous set and clear of the same pending bit (edge coincides with the grant clear): set wins, so the bit stays pending.
- irq_grant_i and irq_done_i asserted in the same cycle while in REQ: only the grant is honoured; done must come later.
- Back-to-back: reaching IDLE with cand!=0 gives REQ on the next edge, so there is at least one IDLE cycle between interrupts.
- Reset mid-operation (REQ or ACTIVE) drops everything immediately. Pending interrupts are lost.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq_src_i passes through a 2-flop synchronizer before edge detect. Request latency increases by 2 cycles. Synchronizer flops reset to 0.
- Undefined: irq_src_i is assumed synchronous to clk and is used directly.

Decomposition:
- Shared package irq_pkg:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, ACTIVE=2'd2.
  - Default VEC_BASE/VEC_STRIDE constants.
  - A function computing vector address from id.
- One natural sub-module: irq_prio_enc, a parameterised lowest-index-first priority encoder with outputs valid and idx[ID_W-1:0].

Test Plan:
- Reset, enable=8'hFF, pulse src[3] (0→1): pending_o=8'h08 after E0; irq_req_o=1, irq_id_o=3, irq_addr_o=32'h10C after E1. Grant: pending_o=0, irq_active_o=1. Done: back to IDLE.
- Raise src[5] and src[2] in the same cycle: id=2, addr=32'h108 served first. After done, id=5, addr=32'h114.
- enable=8'h00, pulse src[1]: pending_o=8'h02, irq_req_o stays 0. Then write enable=8'h02: irq_req_o=1 two edges later.
- In REQ for id=4, raise src[0]: id stays 4 and addr stays 32'h110 until grant. src[0] is served next.
- Pulse src[6] twice while pending: overrun_o[6]=1. An edge on src[6] in the exact grant cycle leaves pending[6]=1.
- Drop reset in ACTIVE: all outputs return to reset values asynchronously. With IRQ_SYNC_EN, request appears 2 cycles later than in scenario 1.
